// File: rtl/apb_regfile_ws.sv
// APB4 slave register file: byte-strobed RW registers, live-input RO registers,
// programmable wait states, error responses and per-register write pulses.
module apb_regfile_ws #(
  parameter int              REGWIDTH     = 32,
  parameter int              N_REGS       = 4,
  parameter int              G_ADDR_WIDTH = $clog2(N_REGS) + $clog2(REGWIDTH/8),
  parameter int              WAIT_STATES  = 0,
  parameter logic [N_REGS-1:0] RO_MASK    = '0,
  parameter bit              PRIV_ONLY    = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_apb_psel,
  input  logic                         s_apb_penable,
  input  logic                         s_apb_pwrite,
  input  logic [2:0]                   s_apb_pprot,
  input  logic [G_ADDR_WIDTH-1:0]      s_apb_paddr,
  input  logic [REGWIDTH-1:0]          s_apb_pwdata,
  input  logic [REGWIDTH/8-1:0]        s_apb_pstrb,
  output logic                         s_apb_pready,
  output logic [REGWIDTH-1:0]          s_apb_prdata,
  output logic                         s_apb_pslverr,
  input  logic [N_REGS*REGWIDTH-1:0]   hw_rdata,
  output logic [N_REGS*REGWIDTH-1:0]   hw_q,
  output logic [N_REGS-1:0]            hw_wr_pulse
);
  localparam int NBYTES   = REGWIDTH / 8;
  localparam int ADDR_LSB = $clog2(NBYTES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                    state_q, state_d;
  logic [3:0]                wait_cnt_q;
  logic [G_ADDR_WIDTH-1:0]   addr_q;
  logic                      write_q;
  logic                      priv_q;
  logic [REGWIDTH-1:0]       wdata_q;
  logic [NBYTES-1:0]         strb_q;
  logic [REGWIDTH-1:0]       rdata_q;
  logic                      slverr_q;
  logic [REGWIDTH-1:0]       regs      [N_REGS];
  logic [REGWIDTH-1:0]       hw_rd_arr [N_REGS];

  logic [31:0]               idx;
  logic [N_REGS-1:0]         hit;
  logic                      in_range, ro_sel, dec_err, commit;
  logic [REGWIDTH-1:0]       rd_val;

  // Only the privileged bit of pprot matters here.
  logic unused_prot;
  assign unused_prot = ^s_apb_pprot[2:1];

  for (genvar g = 0; g < N_REGS; g++) begin : g_slice
    assign hw_rd_arr[g]                  = hw_rdata[g*REGWIDTH +: REGWIDTH];
    assign hw_q[g*REGWIDTH +: REGWIDTH]  = RO_MASK[g] ? '0 : regs[g];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (s_apb_psel && !s_apb_penable) state_d = S_WAIT;
      S_WAIT: begin
        if (!s_apb_psel)                               state_d = S_IDLE;
        else if (s_apb_penable && wait_cnt_q == 4'd0)  state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_apb_pready  = (state_q == S_RESP);
    s_apb_prdata  = s_apb_pready ? rdata_q : '0;
    s_apb_pslverr = s_apb_pready & slverr_q;
  end

  // Decode works on the address latched at SETUP, not the live bus.
  always_comb begin
    idx      = 32'(addr_q) >> ADDR_LSB;
    in_range = (idx < N_REGS);
    hit      = '0;
    rd_val   = '0;
    for (int i = 0; i < N_REGS; i++) begin
      hit[i] = (idx == 32'(i));
      if (hit[i]) rd_val = RO_MASK[i] ? hw_rd_arr[i] : regs[i];
    end
    ro_sel  = |(hit & RO_MASK);
    dec_err = !in_range || (write_q && ro_sel) || (PRIV_ONLY && !priv_q);
    commit  = (state_q == S_RESP) && write_q && !dec_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      priv_q     <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      rdata_q    <= '0;
      slverr_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && s_apb_psel && !s_apb_penable) begin
        wait_cnt_q <= 4'(WAIT_STATES);
        addr_q     <= s_apb_paddr;
        write_q    <= s_apb_pwrite;
        priv_q     <= s_apb_pprot[0];
        wdata_q    <= s_apb_pwdata;
        strb_q     <= s_apb_pstrb;
      end else if (state_q == S_WAIT && s_apb_psel && s_apb_penable && wait_cnt_q != 4'd0) begin
        wait_cnt_q <= wait_cnt_q - 4'd1;
      end
      // Read data (including live RO inputs) is captured on entry to RESP.
      if (state_q == S_WAIT && state_d == S_RESP) begin
        rdata_q  <= dec_err ? '0 : rd_val;
        slverr_q <= dec_err;
      end
    end
  end

  // NOTE: the register array is reset explicitly because software may read it before any write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
      hw_wr_pulse <= '0;
    end else begin
      hw_wr_pulse <= '0;
      if (commit) begin
        for (int i = 0; i < N_REGS; i++) begin
          if (hit[i]) begin
            hw_wr_pulse[i] <= 1'b1;
            for (int b = 0; b < NBYTES; b++)
              if (strb_q[b]) regs[i][8*b +: 8] <= wdata_q[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_regfile_ws.sv
// Self-checking bench for apb_regfile_ws: three configurations share one APB bus,
// checked against a register-level reference model kept in the bench.
module tb_apb_regfile_ws;
  localparam int RW = 32;
  localparam int NR = 4;
  localparam int AW = 6;
  localparam int ND = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [ND-1:0]     psel;
  logic              penable, pwrite;
  logic [2:0]        pprot;
  logic [AW-1:0]     paddr;
  logic [RW-1:0]     pwdata;
  logic [RW/8-1:0]   pstrb;
  logic [NR*RW-1:0]  hw_rdata;

  logic              pready  [ND];
  logic [RW-1:0]     prdata  [ND];
  logic              pslverr [ND];
  logic [NR*RW-1:0]  hw_q    [ND];
  logic [NR-1:0]     pulse   [ND];

  logic [RW-1:0]     m_regs    [ND][NR];
  int                exp_pulse [ND][NR];
  int                pulse_cnt [ND][NR] = '{default: 0};
  int                compared   = 0;
  int                mismatched = 0;

  always #5 clk = ~clk;

  apb_regfile_ws #(.REGWIDTH(RW), .N_REGS(NR), .G_ADDR_WIDTH(AW), .WAIT_STATES(0),
                   .RO_MASK(4'b0000), .PRIV_ONLY(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .s_apb_psel(psel[0]), .s_apb_penable(penable),
    .s_apb_pwrite(pwrite), .s_apb_pprot(pprot), .s_apb_paddr(paddr),
    .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb), .s_apb_pready(pready[0]),
    .s_apb_prdata(prdata[0]), .s_apb_pslverr(pslverr[0]), .hw_rdata(hw_rdata),
    .hw_q(hw_q[0]), .hw_wr_pulse(pulse[0]));

  apb_regfile_ws #(.REGWIDTH(RW), .N_REGS(NR), .G_ADDR_WIDTH(AW), .WAIT_STATES(3),
                   .RO_MASK(4'b0010), .PRIV_ONLY(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .s_apb_psel(psel[1]), .s_apb_penable(penable),
    .s_apb_pwrite(pwrite), .s_apb_pprot(pprot), .s_apb_paddr(paddr),
    .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb), .s_apb_pready(pready[1]),
    .s_apb_prdata(prdata[1]), .s_apb_pslverr(pslverr[1]), .hw_rdata(hw_rdata),
    .hw_q(hw_q[1]), .hw_wr_pulse(pulse[1]));

  apb_regfile_ws #(.REGWIDTH(RW), .N_REGS(NR), .G_ADDR_WIDTH(AW), .WAIT_STATES(1),
                   .RO_MASK(4'b1000), .PRIV_ONLY(1'b1)) u_dut_c (
    .clk(clk), .rst(rst), .s_apb_psel(psel[2]), .s_apb_penable(penable),
    .s_apb_pwrite(pwrite), .s_apb_pprot(pprot), .s_apb_paddr(paddr),
    .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb), .s_apb_pready(pready[2]),
    .s_apb_prdata(prdata[2]), .s_apb_pslverr(pslverr[2]), .hw_rdata(hw_rdata),
    .hw_q(hw_q[2]), .hw_wr_pulse(pulse[2]));

  // Independent pulse counter: each pulse must be seen exactly once per successful write.
  always @(negedge clk) begin
    if (!rst)
      for (int d = 0; d < ND; d++)
        for (int i = 0; i < NR; i++)
          if (pulse[d][i]) pulse_cnt[d][i] = pulse_cnt[d][i] + 1;
  end

  function automatic int ws_of(input int d);
    case (d)
      0:       return 0;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic logic [NR-1:0] ro_of(input int d);
    case (d)
      0:       return 4'b0000;
      1:       return 4'b0010;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic bit priv_of(input int d);
    return (d == 2);
  endfunction

  function automatic logic [NR*RW-1:0] exp_hwq(input int d);
    logic [NR*RW-1:0] v;
    logic [NR-1:0]    ro;
    v  = '0;
    ro = ro_of(d);
    for (int i = 0; i < NR; i++)
      if (!ro[i]) v[i*RW +: RW] = m_regs[d][i];
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < NR; i++) m_regs[d][i] = '0;
  endtask

  task automatic check(input string tag, input logic [NR*RW-1:0] obs, input logic [NR*RW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete APB transfer to configuration d; the next SETUP may follow immediately.
  task automatic xfer(input int d, input bit wr, input logic [AW-1:0] addr,
                      input logic [RW-1:0] wd, input logic [RW/8-1:0] st,
                      input logic [2:0] pr, output logic [RW-1:0] rd_o);
    int              idx, lat;
    bit              err_e;
    logic [NR-1:0]   ro, pulse_e;
    logic [RW-1:0]   rd_e, mask;
    logic            err_o;
    idx   = int'(addr) / (RW/8);
    ro    = ro_of(d);
    err_e = (idx >= NR) || (priv_of(d) && !pr[0]);
    if (!err_e && wr && ro[idx]) err_e = 1'b1;
    rd_e  = '0;
    if (!err_e) rd_e = ro[idx] ? hw_rdata[idx*RW +: RW] : m_regs[d][idx];

    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wd;
    pstrb   = st;
    pprot   = pr;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (pready[d]) begin
        lat = c;
        break;
      end
    end
    rd_o  = prdata[d];
    err_o = pslverr[d];
    check($sformatf("d%0d_latency", d), lat, ws_of(d) + 1);
    check($sformatf("d%0d_pslverr a=%0h", d, addr), err_o, err_e);
    if (!wr) check($sformatf("d%0d_prdata a=%0h", d, addr), rd_o, rd_e);

    pulse_e = '0;
    if (wr && !err_e) begin
      mask = '0;
      for (int b = 0; b < RW/8; b++) if (st[b]) mask = mask | (32'hFF << (8*b));
      m_regs[d][idx] = (m_regs[d][idx] & ~mask) | (wd & mask);
      exp_pulse[d][idx]++;
      pulse_e[idx] = 1'b1;
    end
    @(posedge clk); #1;
    check($sformatf("d%0d_pready_drop", d), pready[d], 1'b0);
    check($sformatf("d%0d_prdata_idle", d), prdata[d], '0);
    check($sformatf("d%0d_wr_pulse", d), pulse[d], pulse_e);
    check($sformatf("d%0d_hw_q", d), hw_q[d], exp_hwq(d));
    psel    = '0;
    penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] rd;
    rst      = 1'b1;
    psel     = '0;
    penable  = 1'b0;
    pwrite   = 1'b0;
    pprot    = 3'b000;
    paddr    = '0;
    pwdata   = '0;
    pstrb    = '0;
    hw_rdata = '0;
    model_reset();
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < NR; i++) exp_pulse[d][i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d_rst_pready", d), pready[d], 1'b0);
      check($sformatf("d%0d_rst_prdata", d), prdata[d], '0);
      check($sformatf("d%0d_rst_pslverr", d), pslverr[d], 1'b0);
      check($sformatf("d%0d_rst_hw_q", d), hw_q[d], '0);
      check($sformatf("d%0d_rst_pulse", d), pulse[d], '0);
    end

    // Three wait states: read of reg0 straight after reset.
    xfer(1, 1'b0, 6'h00, '0, '0, 3'b000, rd);
    check("ws3_read0_value", rd, 32'h0);

    // Zero wait states: write then read back the same register.
    xfer(0, 1'b1, 6'h04, 32'hDEADBEEF, 4'hF, 3'b000, rd);
    xfer(0, 1'b0, 6'h04, '0, '0, 3'b000, rd);
    check("ws0_readback", rd, 32'hDEADBEEF);
    check("ws0_pulse_count_reg1", pulse_cnt[0][1], 1);

    // Byte strobes.
    xfer(0, 1'b1, 6'h08, 32'h11223344, 4'hF, 3'b000, rd);
    xfer(0, 1'b1, 6'h08, 32'hAABBCCDD, 4'b0100, 3'b000, rd);
    xfer(0, 1'b0, 6'h08, '0, '0, 3'b000, rd);
    check("strobe_byte2", rd, 32'h11BB3344);
    xfer(0, 1'b1, 6'h08, 32'hAABBCCDD, 4'b0101, 3'b000, rd);
    xfer(0, 1'b0, 6'h0A, '0, '0, 3'b000, rd);
    check("strobe_bytes0_2", rd, 32'h11BB33DD);
    xfer(0, 1'b1, 6'h0C, 32'h12345678, 4'b0000, 3'b000, rd);

    // Out-of-range address.
    xfer(0, 1'b0, 6'h10, '0, '0, 3'b000, rd);
    check("oor_read_prdata", rd, 32'h0);
    xfer(0, 1'b1, 6'h10, 32'hFFFFFFFF, 4'hF, 3'b000, rd);

    // RO register: write rejected, read returns live input.
    hw_rdata[RW +: RW] = 32'h0000CAFE;
    xfer(1, 1'b1, 6'h04, 32'h5A5A5A5A, 4'hF, 3'b000, rd);
    xfer(1, 1'b0, 6'h04, '0, '0, 3'b000, rd);
    check("ro_live_read", rd, 32'h0000CAFE);
    check("ro_no_pulse", pulse_cnt[1][1], 0);

    // Privilege checking.
    xfer(2, 1'b1, 6'h00, 32'h0BADF00D, 4'hF, 3'b000, rd);
    xfer(2, 1'b0, 6'h00, '0, '0, 3'b000, rd);
    xfer(2, 1'b1, 6'h00, 32'h600DF00D, 4'hF, 3'b001, rd);
    xfer(2, 1'b0, 6'h00, '0, '0, 3'b001, rd);
    check("priv_readback", rd, 32'h600DF00D);

    // Reset asserted mid-WAIT during a write of 0x5 to reg0 of the 3-wait-state slave.
    psel    = 3'b010;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 6'h00;
    pwdata  = 32'h5;
    pstrb   = 4'hF;
    pprot   = 3'b000;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rstmid_pready", pready[1], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rstmid_pready_held", pready[1], 1'b0);
    psel    = '0;
    penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("rstmid_hw_q", hw_q[1], '0);
    check("rstmid_no_pulse", pulse_cnt[1][0], exp_pulse[1][0]);
    xfer(1, 1'b0, 6'h00, '0, '0, 3'b000, rd);
    check("rstmid_reg0_zero", rd, 32'h0);
    xfer(1, 1'b1, 6'h00, 32'h00000007, 4'hF, 3'b000, rd);
    xfer(1, 1'b0, 6'h00, '0, '0, 3'b000, rd);
    check("post_rst_write", rd, 32'h7);

    // Randomized transfers across all three slaves.
    for (int n = 0; n < 90; n++) begin
      int d;
      d = $urandom_range(0, ND - 1);
      for (int k = 0; k < NR; k++) hw_rdata[k*RW +: RW] = $urandom;
      xfer(d, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 23)), $urandom,
           4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), rd);
    end

    for (int d = 0; d < ND; d++)
      for (int i = 0; i < NR; i++)
        check($sformatf("d%0d_pulse_total_reg%0d", d, i), pulse_cnt[d][i], exp_pulse[d][i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
